// File: rtl/data_mem_responder.sv
// Data-side memory responder: 512-byte read-first RAM plus an MMIO page (LED, cycle counter,
// tohost/halt, scratch). Load data is registered, returning one cycle after the address is sampled.
module data_mem_responder #(
  parameter int RAM_WORDS = 128,
  parameter int LED_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           data_address,
  input  logic [31:0]          data_out,
  input  logic [3:0]           width,
  input  logic                 write_mem,
  output logic [31:0]          data_in,
  output logic [LED_WIDTH-1:0] led,
  output logic                 halt,
  output logic [31:0]          tohost_value,
  output logic                 err
);

  localparam logic [6:0] OFF_LED     = 7'd0;
  localparam logic [6:0] OFF_CYCLE   = 7'd1;
  localparam logic [6:0] OFF_TOHOST  = 7'd2;
  localparam logic [6:0] OFF_SCRATCH = 7'd3;

  logic [31:0]          ram_q [RAM_WORDS];
  logic [31:0]          data_in_q, data_in_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [31:0]          cycle_q, cycle_d;
  logic [31:0]          scratch_q, scratch_d;
  logic [31:0]          tohost_q, tohost_d;
  logic                 halt_q, halt_d;
  logic                 err_q, err_d;

  logic        is_mmio;
  logic [6:0]  word_idx;
  logic        full_word;
  logic [31:0] lane_mask;
  logic        unused_addr_bits;

  assign is_mmio          = data_address[9];
  assign word_idx         = data_address[8:2];
  assign full_word        = (width == 4'b1111);
  assign lane_mask        = {{8{width[3]}}, {8{width[2]}}, {8{width[1]}}, {8{width[0]}}};
  assign unused_addr_bits = ^data_address[1:0];

  // Reads always see pre-edge state, which gives read-first behaviour on a same-word store.
  always_comb begin
    data_in_d = 32'h0;
    led_d     = led_q;
    cycle_d   = cycle_q + 32'd1;
    scratch_d = scratch_q;
    tohost_d  = tohost_q;
    halt_d    = halt_q;
    err_d     = err_q;

    if (!is_mmio) begin
      data_in_d = ram_q[word_idx];
    end else begin
      case (word_idx)
        OFF_LED:     data_in_d = 32'(led_q);
        OFF_CYCLE:   data_in_d = cycle_q;
        OFF_TOHOST:  data_in_d = tohost_q;
        OFF_SCRATCH: data_in_d = scratch_q;
        default:     data_in_d = 32'h0;
      endcase
    end

    if (write_mem) begin
      if (width == 4'b0000) err_d = 1'b1;
      if (is_mmio) begin
        case (word_idx)
          OFF_LED: begin
            if (width[0]) led_d = data_out[LED_WIDTH-1:0];
          end
          OFF_CYCLE: err_d = 1'b1;
          OFF_TOHOST: begin
            if (!full_word) begin
              err_d = 1'b1;
            end else if (!halt_q && (data_out != 32'h0)) begin
              halt_d   = 1'b1;
              tohost_d = data_out;
            end
          end
          OFF_SCRATCH: scratch_d = (scratch_q & ~lane_mask) | (data_out & lane_mask);
          default:     err_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_in_q <= 32'h0;
      led_q     <= '0;
      cycle_q   <= 32'h0;
      scratch_q <= 32'h0;
      tohost_q  <= 32'h0;
      halt_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      data_in_q <= data_in_d;
      led_q     <= led_d;
      cycle_q   <= cycle_d;
      scratch_q <= scratch_d;
      tohost_q  <= tohost_d;
      halt_q    <= halt_d;
      err_q     <= err_d;
    end
  end

  // RAM is never cleared; reset only suppresses a store landing on the reset edge.
  always_ff @(posedge clk) begin
    if (rst_n && write_mem && !is_mmio) begin
      for (int n = 0; n < 4; n++) begin
        if (width[n]) ram_q[word_idx][8*n +: 8] <= data_out[8*n +: 8];
      end
    end
  end

  assign data_in      = data_in_q;
  assign led          = led_q;
  assign halt         = halt_q;
  assign tohost_value = tohost_q;
  assign err          = err_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-side memory responder at the far end of the CPU data port: address, store data, byte-enable `width`, `write_mem` in; `data_in` back.
- Contains a 512-byte synchronous RAM plus a small memory-mapped I/O page: LED register, free-running cycle counter, tohost/halt register and scratch register.
- Read data is registered with 1-cycle latency, which matches the CPU capturing the load result in writeback one cycle after the memory stage presents the address.

Parameters:
- RAM_WORDS, 128, number of 32-bit RAM words; fixed to match the address[8:2] index.
- LED_WIDTH, 8, width of the LED output register.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- data_address  input  10  byte address from CPU memory stage
- data_out  input  32  store data from CPU, already lane-aligned
- width  input  4  byte-lane enables for stores (bit n -> bits 8n+7:8n)
- write_mem  input  1  store strobe for the current cycle
- data_in  output  32  registered load data returned to CPU
- led  output  LED_WIDTH  LED register contents
- halt  output  1  sticky, set by first nonzero tohost write
- tohost_value  output  32  value latched at halt
- err  output  1  sticky access-error flag

Behaviour:
- Address decode: word index = data_address[9:2]; data_address[1:0] ignored.
  - data_address[9]=0: RAM, word index data_address[8:2].
  - data_address[9]=1: MMIO.
    - 0x200 LED (R/W)
    - 0x204 CYCLE (RO)
    - 0x208 TOHOST (W; read returns tohost_value)
    - 0x20C SCRATCH (R/W)
    - 0x210-0x3FC unmapped: read 0, write ignored.
- Reads: every cycle, whether or not write_mem is set, data_in <= word at sampled address on the rising edge; 1-cycle latency; no handshake, no stalls.
- Stores: when write_mem=1, each lane with width[n]=1 is written at the edge; lanes with width[n]=0 are kept.
- Read-during-write to the same word: read-first. data_in next cycle = contents before the store; the new value is visible from the following access.
- LED:
  - Write updates only from lane 0 when width[0]=1, led <= data_out[LED_WIDTH-1:0].
  - Read returns zero-extended led.
- CYCLE:
  - 32-bit counter, 0 after reset, +1 every cycle, wraps 0xFFFFFFFF -> 0.
  - Read returns the counter value held before the sampling edge's increment.
  - Writes are ignored and set err.
- TOHOST:
  - Applies when write_mem=1 with width=4'b1111, halt=0, data_out != 0: tohost_value <= data_out, halt <= 1.
  - A zero write has no effect.
  - Writes after halt=1 are ignored (first value wins).
  - Partial-width write sets err and does not halt.
- SCRATCH: full byte-lane R/W, reset 0.
- err: set (sticky) on any of the following, cleared only by reset:
  - write_mem=1 with width=4'b0000
  - write to CYCLE
  - partial TOHOST write
  - write to unmapped MMIO
- Reset (rst_n=0 at an edge) applies on that edge, overriding any concurrent store:
  - data_in=0, led=0, CYCLE=0, SCRATCH=0, halt=0, tohost_value=0, err=0.
  - RAM contents are not cleared; they are preserved across reset and undefined at power-up.
- Reset mid-store: the store at the reset edge is not performed, for RAM and MMIO alike.
- Counter first reads 0 on the cycle after rst_n deasserts, provided the read is sampled at the first non-reset edge.
- Back-to-back store then load of the same word: the load, sampled one cycle after the store, returns the new data.

Test Plan:
- Word store/load: write 0xDEADBEEF, width=1111, to 0x010; next cycle read 0x010 -> data_in=0xDEADBEEF one cycle after the read address.
- Byte lanes: RAM 0x014 holds 0x11223344; store data_out=0xAABBCCDD width=0100 -> read 0x014 = 0x11BB3344. Then width=0000 store -> data unchanged, err=1.
- Read-during-write: 0x018 holds 0x1; store 0x2 with a read of the same address in the same cycle -> data_in=0x1 next cycle; a following read returns 0x2.
- MMIO:
  - Write 0x000000A5 width=0001 to 0x200 -> led=0xA5.
  - Read 0x204 on two consecutive cycles -> values differ by 1.
  - Write to 0x204 -> err=1, counter unaffected.
- Halt: write 0 to 0x208 -> halt=0. Write 0x00000001 -> halt=1, tohost_value=1. Write 0x5 -> tohost_value stays 1. Read 0x208 -> 1.
- Reset: with led=0xA5, halt=1, err=1, assert rst_n=0 for one edge concurrent with a RAM store to 0x020 -> all outputs 0. RAM 0x020 keeps its old value; RAM 0x010 still reads 0xDEADBEEF.
